enose_window_sched: RTL and testbench
=====================================

// Module: enose_window_sched
// PURPOSE
//  Window scheduler that sits between the spike encoder and the SNN inference core (enose_accel).
//  It buffers per-timestep spike masks in a FIFO and groups them into windows of window_len words.
//  For each window it pulses a core reset, then a core start, then streams the window over AXI-Stream with TLAST.
//  It waits for the core's DONE, captures the class and then schedules the next window.
// PARAMETERS
//  N_IN        12     spike-mask width (channels)
//  FIFO_DEPTH  16     mask FIFO depth, power of 2, >=2
//  WLEN_MAX    64     maximum window length in words
//  GAP_CYC     3      idle cycles between core_rst and core_start
//  TIMEOUT_CYC 65535  maximum cycles spent in WAIT before aborting
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous, active-high reset
//  enable        in   1      1 = schedule windows continuously
//  window_len    in   7      words per window; sampled on leaving IDLE
//  mask_in       in   N_IN   spike mask from encoder
//  mask_valid    in   1      mask_in valid this cycle (push request)
//  core_rst      out  1      1-cycle core clear pulse
//  core_start    out  1      1-cycle core start pulse
//  m_axis_tdata  out  32     {zeros, FIFO head}
//  m_axis_tvalid out  1      stream valid
//  m_axis_tready in   1      stream ready from core
//  m_axis_tlast  out  1      high on the last word of the window
//  core_done     in   1      core DONE status, level
//  core_class    in   2      core RESULT_CLASS, valid while core_done=1
//  result_valid  out  1      1-cycle pulse, result_class updated
//  result_class  out  2      class of the last completed window
//  win_count     out  16     completed windows, wraps 0xFFFF->0
//  busy          out  1      FSM not in IDLE
//  overflow      out  1      sticky: a mask was dropped because the FIFO was full
//  timeout_err   out  1      sticky: WAIT phase expired
// BEHAVIOUR
//  Reset state:
//   - all outputs are 0; FIFO is empty; FSM is in IDLE.
//   - rst asserted mid-window aborts the window immediately; no partial TLAST is sent.
//  FIFO:
//   - Push when mask_valid=1 and not full; if full, drop the mask and set overflow.
//   - Pop on m_axis_tvalid & m_axis_tready.
//   - Push and pop in the same cycle are both honoured even when the FIFO is full, so the count is unchanged.
//   - The FIFO accepts pushes in every state.
//  Effective window length L:
//   - window_len=0 -> L=1.
//   - window_len>WLEN_MAX -> L=WLEN_MAX.
//   - L is latched at IDLE->CLR and held for the whole window.
//  FSM:
//   - IDLE: go to CLR when enable=1.
//   - CLR: core_rst=1 for exactly 1 cycle -> GAP.
//   - GAP: wait GAP_CYC cycles -> START.
//   - START: core_start=1 for exactly 1 cycle -> STREAM.
//   - STREAM:
//     - m_axis_tvalid = FIFO not empty.
//     - tdata = FIFO head, zero-extended to 32 bits.
//     - tlast = (beat count == L-1).
//     - Once tvalid is asserted it stays asserted with stable data until the handshake completes.
//     - After the L-th handshake -> WAIT; the beat counter resets to 0 on entry to STREAM.
//   - WAIT:
//     - Count cycles; when core_done=1, capture core_class and go to RESULT.
//     - If TIMEOUT_CYC cycles pass without core_done: set timeout_err, do not pulse result_valid, go to IDLE.
//   - RESULT:
//     - result_valid=1 for 1 cycle; result_class is updated in the same cycle.
//     - win_count increments -> IDLE.
//  Back-to-back windows:
//   - With enable held at 1, IDLE->CLR follows on the next cycle.
//   - The CLR pulse clears the core's stale DONE before any new WAIT.
//  enable=0 mid-window: the current window completes through RESULT, then the FSM stays in IDLE.
//  core_done is ignored in every state except WAIT.
//  m_axis_tvalid is 0 in every state except STREAM.
// TESTING
//  - Reset -> all outputs 0; enable=0 with 5 pushes -> busy=0, no core_rst/core_start pulses.
//  - L=10, 10 masks 0xFFF, tready=1, core_done 4 cycles after the last beat with class=2 -> exactly 10 beats, tlast only on beat 10, result_valid once, result_class=2, win_count=1.
//  - tready toggling 1/0 every cycle during STREAM -> tdata/tvalid stable while stalled; beat order matches push order.
//  - 17 pushes with tready=0 and FIFO_DEPTH=16 -> overflow=1, 16 masks retained, 17th dropped.
//  - window_len=0 -> 1-beat window with tlast=1; window_len=100 -> 64 beats.
//  - core_done held 0 -> timeout_err=1 after 65535 WAIT cycles, no result_valid; rst during STREAM -> tvalid=0 next cycle, FIFO empty.

Source files
------------

// File: rtl/enose_window_sched.sv
// enose_window_sched
//   Window scheduler between the spike encoder and the SNN inference core.
//   Incoming spike masks are buffered in a FIFO. Each window clears the core,
//   waits a short gap, starts the core, streams L masks over AXI-Stream with
//   TLAST on the final beat, then waits for the core's DONE and captures its class.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   enable                        1 = keep scheduling windows
//   window_len[6:0]               words per window (0 -> 1, >WLEN_MAX -> WLEN_MAX)
//   mask_in, mask_valid           encoder push interface
//   core_rst, core_start          1-cycle core control pulses
//   m_axis_tdata/tvalid/tready/tlast  mask stream to the core
//   core_done, core_class         core completion status and result
//   result_valid, result_class    1-cycle result pulse and last class
//   win_count                     completed windows (wraps)
//   busy                          FSM not idle
//   overflow, timeout_err         sticky error flags
module enose_window_sched #(
   parameter int unsigned N_IN        = 12,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned WLEN_MAX    = 64,
   parameter int unsigned GAP_CYC     = 3,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            enable,
   input  logic [6:0]      window_len,
   input  logic [N_IN-1:0] mask_in,
   input  logic            mask_valid,
   output logic            core_rst,
   output logic            core_start,
   output logic [31:0]     m_axis_tdata,
   output logic            m_axis_tvalid,
   input  logic            m_axis_tready,
   output logic            m_axis_tlast,
   input  logic            core_done,
   input  logic [1:0]      core_class,
   output logic            result_valid,
   output logic [1:0]      result_class,
   output logic [15:0]     win_count,
   output logic            busy,
   output logic            overflow,
   output logic            timeout_err
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CLR, S_GAP, S_START, S_STREAM, S_WAIT, S_RESULT
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN-1:0]   mem_q [FIFO_DEPTH];
   logic [N_IN-1:0]   mem_d [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [6:0]        len_q, len_d;
   logic [6:0]        beat_q, beat_d;
   logic [CW-1:0]     cyc_q, cyc_d;
   logic              core_rst_q, core_rst_d;
   logic              core_start_q, core_start_d;
   logic              result_valid_q, result_valid_d;
   logic [1:0]        result_class_q, result_class_d;
   logic [15:0]       win_count_q, win_count_d;
   logic              busy_q, busy_d;
   logic              overflow_q, overflow_d;
   logic              timeout_err_q, timeout_err_d;

   logic              fifo_empty, fifo_full;
   logic              tvalid, pop, push;
   logic [6:0]        len_eff;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));

   // tvalid derives from flops only; in STREAM the FIFO can only shrink via a
   // handshake, so a raised tvalid cannot fall before it is accepted.
   assign tvalid = (state_q == S_STREAM) && !fifo_empty;
   assign pop    = tvalid && m_axis_tready;
   // A push into a full FIFO still lands when a pop frees a slot this cycle.
   assign push   = mask_valid && (!fifo_full || pop);

   always_comb begin
      if (window_len == 7'd0) begin
         len_eff = 7'd1;
      end else if (32'(window_len) > WLEN_MAX) begin
         len_eff = 7'(WLEN_MAX);
      end else begin
         len_eff = window_len;
      end
   end

   always_comb begin
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q | (mask_valid & ~push);
      if (push) begin
         mem_d[wr_ptr_q] = mask_in;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_comb begin
      state_d        = state_q;
      len_d          = len_q;
      beat_d         = beat_q;
      cyc_d          = cyc_q;
      result_class_d = result_class_q;
      win_count_d    = win_count_q;
      timeout_err_d  = timeout_err_q;

      case (state_q)
         S_IDLE: begin
            if (enable) begin
               state_d = S_CLR;
               len_d   = len_eff;
            end
         end
         S_CLR: begin
            state_d = S_GAP;
            cyc_d   = '0;
         end
         S_GAP: begin
            if (cyc_q == CW'(GAP_CYC - 1)) begin
               state_d = S_START;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_START: begin
            state_d = S_STREAM;
            beat_d  = '0;
         end
         S_STREAM: begin
            if (pop) begin
               if (beat_q == len_q - 7'd1) begin
                  state_d = S_WAIT;
                  cyc_d   = '0;
               end else begin
                  beat_d = beat_q + 7'd1;
               end
            end
         end
         S_WAIT: begin
            if (core_done) begin
               state_d        = S_RESULT;
               result_class_d = core_class;
               win_count_d    = win_count_q + 16'd1;
            end else if (cyc_q == CW'(TIMEOUT_CYC - 1)) begin
               state_d       = S_IDLE;
               timeout_err_d = 1'b1;
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end
         S_RESULT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Pulse outputs are registered from the next state so they line up
      // exactly with the cycle spent in the corresponding state.
      core_rst_d     = (state_d == S_CLR);
      core_start_d   = (state_d == S_START);
      result_valid_d = (state_d == S_RESULT);
      busy_d         = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         len_q          <= '0;
         beat_q         <= '0;
         cyc_q          <= '0;
         core_rst_q     <= 1'b0;
         core_start_q   <= 1'b0;
         result_valid_q <= 1'b0;
         result_class_q <= '0;
         win_count_q    <= '0;
         busy_q         <= 1'b0;
         overflow_q     <= 1'b0;
         timeout_err_q  <= 1'b0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         len_q          <= len_d;
         beat_q         <= beat_d;
         cyc_q          <= cyc_d;
         core_rst_q     <= core_rst_d;
         core_start_q   <= core_start_d;
         result_valid_q <= result_valid_d;
         result_class_q <= result_class_d;
         win_count_q    <= win_count_d;
         busy_q         <= busy_d;
         overflow_q     <= overflow_d;
         timeout_err_q  <= timeout_err_d;
      end
      mem_q <= mem_d;
   end

   assign core_rst      = core_rst_q;
   assign core_start    = core_start_q;
   assign m_axis_tvalid = tvalid;
   assign m_axis_tdata  = tvalid ? 32'(mem_q[rd_ptr_q]) : '0;
   assign m_axis_tlast  = tvalid && (beat_q == len_q - 7'd1);
   assign result_valid  = result_valid_q;
   assign result_class  = result_class_q;
   assign win_count     = win_count_q;
   assign busy          = busy_q;
   assign overflow      = overflow_q;
   assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_enose_window_sched.sv
module tb_enose_window_sched;

   localparam int N_IN       = 12;
   localparam int FIFO_DEPTH = 16;

   logic            clk;
   logic            rst;
   logic            enable;
   logic [6:0]      window_len;
   logic [N_IN-1:0] mask_in;
   logic            mask_valid;
   logic            core_rst;
   logic            core_start;
   logic [31:0]     m_axis_tdata;
   logic            m_axis_tvalid;
   logic            m_axis_tready;
   logic            m_axis_tlast;
   logic            core_done;
   logic [1:0]      core_class;
   logic            result_valid;
   logic [1:0]      result_class;
   logic [15:0]     win_count;
   logic            busy;
   logic            overflow;
   logic            timeout_err;

   enose_window_sched #(
      .N_IN(12), .FIFO_DEPTH(16), .WLEN_MAX(64), .GAP_CYC(3), .TIMEOUT_CYC(65535)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .window_len(window_len),
      .mask_in(mask_in), .mask_valid(mask_valid),
      .core_rst(core_rst), .core_start(core_start),
      .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
      .core_done(core_done), .core_class(core_class),
      .result_valid(result_valid), .result_class(result_class),
      .win_count(win_count), .busy(busy), .overflow(overflow),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   logic [N_IN-1:0] mq[$];
   logic [N_IN-1:0] exp_m;
   logic            ovf_exp = 1'b0;
   int              l_exp = 1;
   int              beat_in_win = 0;
   logic [15:0]     win_exp = '0;
   logic [1:0]      cls_exp = '0;
   int              n_rstp = 0, n_startp = 0, n_rv = 0, n_beats = 0, n_tlast = 0;
   logic            prev_stall = 1'b0;
   logic [31:0]     prev_data = '0;

   // Core emulation controls
   bit              auto_done = 1'b1;
   int              done_delay = 4;
   logic [1:0]      done_class = 2'd0;
   int              timer = 0;

   // Main-sequence stimulus controls
   bit              toggle_rdy = 1'b0;
   bit              feed = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic int eff_len(input logic [6:0] wl);
      if (wl == 7'd0) return 1;
      if (int'(wl) > 64) return 64;
      return int'(wl);
   endfunction

   // Negedge monitor: scoreboard for the FIFO/stream and a simple core model.
   initial begin
      core_done  = 1'b0;
      core_class = 2'd0;
      forever begin
         @(negedge clk);
         if (rst) begin
            mq.delete();
            ovf_exp     = 1'b0;
            beat_in_win = 0;
            win_exp     = '0;
            prev_stall  = 1'b0;
            timer       = 0;
            core_done   = 1'b0;
         end else begin
            if (prev_stall) begin
               chk("stall_tvalid", 32'(m_axis_tvalid), 32'd1);
               chk("stall_tdata", m_axis_tdata, prev_data);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            if (core_rst) begin
               n_rstp++;
               core_done = 1'b0;
               timer     = 0;
            end
            if (core_start) begin
               n_startp++;
               beat_in_win = 0;
               l_exp       = eff_len(window_len);
            end
            if (timer > 0) begin
               timer--;
               if (timer == 0) begin
                  core_done  = 1'b1;
                  core_class = done_class;
                  cls_exp    = done_class;
               end
            end
            if (m_axis_tvalid && m_axis_tready) begin
               chk("pop_nonempty", 32'(mq.size() != 0), 32'd1);
               if (mq.size() != 0) begin
                  exp_m = mq.pop_front();
                  chk("tdata", m_axis_tdata, 32'(exp_m));
                  chk("tlast", 32'(m_axis_tlast), 32'(beat_in_win == l_exp - 1));
                  n_beats++;
                  if (m_axis_tlast) n_tlast++;
                  beat_in_win++;
                  if (beat_in_win == l_exp && auto_done) timer = done_delay;
               end
            end
            if (mask_valid) begin
               if (mq.size() < FIFO_DEPTH) mq.push_back(mask_in);
               else ovf_exp = 1'b1;
            end
            if (result_valid) begin
               n_rv++;
               win_exp++;
               chk("result_class", 32'(result_class), 32'(cls_exp));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [N_IN-1:0] m);
      mask_valid = 1'b1;
      mask_in    = m;
      tick();
      mask_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   function automatic bit done_cond(input int kind, input int target);
      case (kind)
         0:       return n_rv >= target;
         1:       return n_startp >= target;
         default: return busy == 1'b0;
      endcase
   endfunction

   task automatic run_until(input int kind, input int target, input int budget,
                            input string tag, output int used);
      used = 0;
      while (used < budget && !done_cond(kind, target)) begin
         if (toggle_rdy) m_axis_tready = ~m_axis_tready;
         if (feed) begin
            mask_valid = ($urandom_range(3) != 0);
            mask_in    = N_IN'($urandom);
         end
         tick();
         used++;
      end
      mask_valid = 1'b0;
      chk(tag, 32'(done_cond(kind, target)), 32'd1);
   endtask

   // Runs one window: enable until core_start, then drop enable and wait for the result.
   task automatic one_window(input string tag);
      int used;
      enable = 1'b1;
      run_until(1, n_startp + 1, 100, {tag, "_start"}, used);
      enable = 1'b0;
      run_until(0, n_rv + 1, 3000, {tag, "_result"}, used);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int b0, t0, r0, s0, used;
      logic [15:0] w0;
      int wl;

      rst = 1'b1; enable = 1'b0; window_len = 7'd0; mask_in = '0;
      mask_valid = 1'b0; m_axis_tready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      chk("rst_core_rst", 32'(core_rst), 0);
      chk("rst_core_start", 32'(core_start), 0);
      chk("rst_tvalid", 32'(m_axis_tvalid), 0);
      chk("rst_tdata", m_axis_tdata, 0);
      chk("rst_tlast", 32'(m_axis_tlast), 0);
      chk("rst_result_valid", 32'(result_valid), 0);
      chk("rst_result_class", 32'(result_class), 0);
      chk("rst_win_count", 32'(win_count), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_overflow", 32'(overflow), 0);
      chk("rst_timeout_err", 32'(timeout_err), 0);

      // enable=0 with pushes: nothing scheduled
      for (int i = 0; i < 5; i++) push(N_IN'($urandom));
      repeat (5) tick();
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rst_pulses", 32'(n_rstp), 0);
      chk("idle_start_pulses", 32'(n_startp), 0);
      do_reset();

      // L=10 window of 0xFFF, class 2
      window_len = 7'd10;
      for (int i = 0; i < 10; i++) push(12'hFFF);
      m_axis_tready = 1'b1; done_delay = 4; done_class = 2'd2;
      b0 = n_beats; t0 = n_tlast; r0 = n_rv;
      one_window("w10");
      repeat (3) tick();
      chk("w10_beats", 32'(n_beats - b0), 10);
      chk("w10_tlast", 32'(n_tlast - t0), 1);
      chk("w10_rv", 32'(n_rv - r0), 1);
      chk("w10_class", 32'(result_class), 2);
      chk("w10_win_count", 32'(win_count), 1);
      chk("w10_busy", 32'(busy), 0);
      chk("w10_clr_pulses", 32'(n_rstp), 1);

      // tready toggling during STREAM
      window_len = 7'd8;
      for (int i = 0; i < 8; i++) push(N_IN'($urandom));
      done_class = 2'($urandom); done_delay = $urandom_range(1, 6);
      b0 = n_beats;
      toggle_rdy = 1'b1;
      one_window("tog");
      toggle_rdy = 1'b0; m_axis_tready = 1'b1;
      chk("tog_beats", 32'(n_beats - b0), 8);
      chk("tog_win_count", 32'(win_count), 32'(win_exp));

      // Overflow: 17 pushes with tready=0, then push while full during stream
      do_reset();
      m_axis_tready = 1'b0;
      for (int i = 0; i < 17; i++) push(N_IN'($urandom));
      chk("ovf_flag", 32'(overflow), 1);
      window_len = 7'd16; m_axis_tready = 1'b1;
      b0 = n_beats;
      one_window("ovf");
      chk("ovf_beats", 32'(n_beats - b0), 16);
      chk("ovf_sticky", 32'(overflow), 1);
      chk("ovf_model_empty", 32'(mq.size()), 0);

      // Full FIFO with simultaneous push and pop
      for (int i = 0; i < 16; i++) push(N_IN'($urandom));
      feed = 1'b1;
      done_class = 2'($urandom);
      one_window("full_pp");
      feed = 1'b0;
      do_reset();

      // window_len=0 -> 1 beat; window_len=100 -> 64 beats
      window_len = 7'd0;
      push(N_IN'($urandom));
      b0 = n_beats; t0 = n_tlast;
      one_window("wl0");
      chk("wl0_beats", 32'(n_beats - b0), 1);
      chk("wl0_tlast", 32'(n_tlast - t0), 1);
      window_len = 7'd100;
      b0 = n_beats; t0 = n_tlast;
      feed = 1'b1;
      one_window("wl100");
      feed = 1'b0;
      chk("wl100_beats", 32'(n_beats - b0), 64);
      chk("wl100_tlast", 32'(n_tlast - t0), 1);

      // Back-to-back windows with enable held high
      wl = $urandom_range(1, 20);
      window_len = 7'(wl);
      done_class = 2'($urandom);
      r0 = n_rv; s0 = n_rstp; b0 = n_beats;
      feed = 1'b1; enable = 1'b1;
      run_until(0, r0 + 3, 3000, "b2b_results", used);
      enable = 1'b0;
      run_until(2, 0, 600, "b2b_idle", used);
      feed = 1'b0;
      chk("b2b_win_count", 32'(win_count), 32'(win_exp));
      chk("b2b_clr_per_win", 32'(n_rstp - s0), 32'(n_rv - r0));
      chk("b2b_beats", 32'(n_beats - b0), 32'((n_rv - r0) * wl));
      chk("b2b_overflow", 32'(overflow), 32'(ovf_exp));

      // Timeout: core never reports DONE
      auto_done = 1'b0;
      window_len = 7'd1;
      push(N_IN'($urandom));
      r0 = n_rv; w0 = win_count;
      enable = 1'b1;
      run_until(1, n_startp + 1, 100, "to_start", used);
      enable = 1'b0;
      run_until(2, 0, 70000, "to_idle", used);
      chk("to_len", 32'(used >= 65535), 1);
      chk("to_flag", 32'(timeout_err), 1);
      chk("to_no_result", 32'(n_rv - r0), 0);
      chk("to_win_count", 32'(win_count), 32'(w0));
      auto_done = 1'b1;

      // rst during STREAM
      window_len = 7'd20; m_axis_tready = 1'b0;
      for (int i = 0; i < 5; i++) push(N_IN'($urandom));
      enable = 1'b1;
      run_until(1, n_startp + 1, 100, "rs_start", used);
      tick(); tick();
      chk("rs_streaming", 32'(m_axis_tvalid), 1);
      rst = 1'b1; enable = 1'b0;
      tick();
      chk("rs_tvalid", 32'(m_axis_tvalid), 0);
      chk("rs_busy", 32'(busy), 0);
      chk("rs_timeout_clr", 32'(timeout_err), 0);
      chk("rs_win_count", 32'(win_count), 0);
      rst = 1'b0;
      window_len = 7'd1; m_axis_tready = 1'b1; enable = 1'b1;
      run_until(1, n_startp + 1, 100, "rs2_start", used);
      enable = 1'b0;
      repeat (3) tick();
      chk("rs_fifo_empty", 32'(m_axis_tvalid), 0);
      chk("rs2_busy", 32'(busy), 1);
      push(N_IN'($urandom));
      run_until(0, n_rv + 1, 200, "rs2_result", used);
      tick();
      chk("rs2_win_count", 32'(win_count), 32'(win_exp));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
